// File: rtl/wishbone_master_adapter.sv
// rtl/wishbone_master_adapter.sv - core request to Wishbone classic single-cycle initiator with bus timeout
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    core request handshake (ready only in IDLE)
//   req_addr_i, req_wdata_i,
//   req_we_i, req_sel_i          request payload, latched on acceptance
//   resp_valid_o                 one-cycle response pulse
//   resp_rdata_o, resp_err_o     response payload, valid with resp_valid_o
//   wb_addr_o, wb_data_o,
//   wb_we_o, wb_sel_o,
//   wb_stb_o, wb_cyc_o           Wishbone initiator outputs, all registered
//   wb_data_i, wb_ack_i,
//   wb_err_i                     Wishbone slave response inputs
module wishbone_master_adapter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic          req_we_i,
    input  logic [3:0]    req_sel_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_rdata_o,
    output logic          resp_err_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    input  logic [DW-1:0] wb_data_i,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          timeout_hit;

    // Timeout fires on the cycle the counter reaches its last value, so with
    // TIMEOUT_CYCLES=N the strobe is held for exactly N cycles.
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        sel_d        = sel_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (wb_err_i || wb_ack_i || timeout_hit) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                    // ERR beats ACK; a real ACK beats a coincident timeout.
                    if (wb_err_i) begin
                        resp_err_d = 1'b1;
                        if (!we_q) rdata_d = '0;
                    end else if (wb_ack_i) begin
                        resp_err_d = 1'b0;
                        if (!we_q) rdata_d = wb_data_i;
                    end else begin
                        resp_err_d = 1'b1;
                        if (!we_q) rdata_d = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = resp_err_q;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = wdata_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_stb_o     = stb_q;
    assign wb_cyc_o     = cyc_q;

endmodule

// File: tb/tb_wishbone_master_adapter.sv
// tb/tb_wishbone_master_adapter.sv - self-checking bench for wishbone_master_adapter
module tb_wishbone_master_adapter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdat;
    logic [31:0] wb_rd = '0;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic        force_ack = 1'b0;
    logic        wb_ack;

    assign wb_ack = s_ack | force_ack;

    always #5 clk = ~clk;

    wishbone_master_adapter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_we_i(req_we), .req_sel_i(req_sel),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .wb_addr_o(wb_addr), .wb_data_o(wb_wdat), .wb_data_i(wb_rd),
        .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
        .wb_ack_i(wb_ack), .wb_err_i(s_err)
    );

    // Slave: answers (once) in strobe cycle slave_delay+1, then idles until STB drops.
    int          slave_delay = 1;
    logic        slave_ack = 1'b1;
    logic        slave_err = 1'b0;
    logic [31:0] slave_data = '0;
    int          scnt = 0;

    always @(posedge clk) begin
        s_ack <= 1'b0;
        s_err <= 1'b0;
        wb_rd <= $urandom;
        if (rst || !(wb_cyc && wb_stb)) begin
            scnt <= 0;
        end else begin
            scnt <= scnt + 1;
            if (scnt + 1 == slave_delay) begin
                s_ack <= slave_ack;
                s_err <= slave_err;
                wb_rd <= slave_data;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] sdata;
        int          delay;
        logic        ack;
        logic        err;
        logic        hold;
        logic        exp_err;
        int          exp_stb;
        logic [31:0] exp_rdata;
    } txn_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] prev_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: slave responds only if it answers inside the timeout window.
    function automatic txn_t model(input txn_t t, input logic [31:0] prev);
        txn_t r;
        logic responds;
        r = t;
        responds = (t.ack || t.err) && t.delay >= 1 && (t.delay + 1) <= TO;
        r.exp_stb = responds ? t.delay + 1 : TO;
        r.exp_err = responds ? t.err : 1'b1;
        if (t.we) r.exp_rdata = prev;
        else if (responds && !t.err) r.exp_rdata = t.sdata;
        else r.exp_rdata = 32'h0;
        return r;
    endfunction

    task automatic run_txn(input txn_t t);
        int n;
        int stb_n;
        logic stable;
        logic cyc_eq;
        logic got;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, req_ready}, 32'h1);
        chk("idle_cyc_low", {31'b0, wb_cyc}, 32'h0);
        slave_delay = t.delay;
        slave_ack   = t.ack;
        slave_err   = t.err;
        slave_data  = t.sdata;
        req_valid   = 1'b1;
        req_we      = t.we;
        req_addr    = t.addr;
        req_wdata   = t.wdata;
        req_sel     = t.sel;
        @(posedge clk);
        #1;
        req_valid = t.hold;
        req_we    = ~t.we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_sel   = 4'($urandom);
        stb_n = 0;
        stable = 1'b1;
        cyc_eq = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (wb_cyc !== wb_stb) cyc_eq = 1'b0;
            if (wb_stb) begin
                stb_n++;
                if (wb_addr !== t.addr || wb_wdat !== t.wdata || wb_we !== t.we || wb_sel !== t.sel)
                    stable = 1'b0;
                if (req_ready) stable = 1'b0;
            end
            if (resp_valid) got = 1'b1;
        end
        chk("resp_seen", {31'b0, got}, 32'h1);
        chk("stb_cycles", stb_n, t.exp_stb);
        chk("latency", n, t.exp_stb + 1);
        chk("bus_stable", {31'b0, stable}, 32'h1);
        chk("cyc_eq_stb", {31'b0, cyc_eq}, 32'h1);
        chk("resp_err", {31'b0, resp_err}, {31'b0, t.exp_err});
        chk("resp_rdata", resp_rdata, t.exp_rdata);
        chk("done_ready", {31'b0, req_ready}, 32'h0);
        chk("done_cyc", {31'b0, wb_cyc}, 32'h0);
        prev_rdata = t.exp_rdata;
    endtask

    txn_t tbl[11];
    txn_t rt;

    initial begin
        //        we    addr          wdata         sel   sdata         dly ack err hold  eerr estb erdata
        tbl[0]  = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 32'h20, 32'h12345678, 4'h3, 32'hAAAA5555, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h30, 32'h0, 4'hF, 32'h11112222, 2, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'h0};
        tbl[3]  = '{1'b0, 32'h40, 32'h0, 4'hF, 32'h33334444, 30, 1'b1, 1'b0, 1'b0, 1'b1, 8, 32'h0};
        tbl[4]  = '{1'b0, 32'h44, 32'h0, 4'hF, 32'hCAFEF00D, 7, 1'b1, 1'b0, 1'b0, 1'b0, 8, 32'hCAFEF00D};
        tbl[5]  = '{1'b0, 32'h48, 32'h0, 4'h1, 32'h55556666, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8, 32'h0};
        tbl[6]  = '{1'b0, 32'h4C, 32'h0, 4'hF, 32'h77778888, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h77778888};
        tbl[7]  = '{1'b1, 32'h50, 32'hABCD0123, 4'hC, 32'h99990000, 3, 1'b0, 1'b1, 1'b0, 1'b1, 4, 32'h77778888};
        tbl[8]  = '{1'b0, 32'h60, 32'h0, 4'hF, 32'h01010101, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h01010101};
        tbl[9]  = '{1'b0, 32'h64, 32'h0, 4'hF, 32'h02020202, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h02020202};
        tbl[10] = '{1'b0, 32'h68, 32'h0, 4'hF, 32'h03030303, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h03030303};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_cyc_stb_we", {29'b0, wb_cyc, wb_stb, wb_we}, 32'h0);
        chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
        chk("rst_addr", wb_addr, 32'h0);
        chk("rst_wdata", wb_wdat, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_sel", {28'b0, wb_sel}, 32'h0);

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // Late ACK three cycles after a timed-out response must be ignored.
        rt = '{1'b0, 32'h70, 32'h0, 4'hF, 32'hBEEFBEEF, 50, 1'b0, 1'b0, 1'b0, 1'b1, 8, 32'h0};
        run_txn(rt);
        repeat (3) @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        begin
            logic quiet;
            quiet = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (resp_valid || wb_cyc || !req_ready) quiet = 1'b0;
            end
            chk("late_ack_ignored", {31'b0, quiet}, 32'h1);
        end
        chk("late_ack_rdata", resp_rdata, 32'h0);

        // Reset one cycle into BUS aborts the cycle without a response.
        @(negedge clk);
        slave_delay = 50;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_stb_up", {31'b0, wb_stb}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic quiet;
            quiet = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (resp_valid || wb_cyc) quiet = 1'b0;
            end
            chk("abort_quiet", {31'b0, quiet}, 32'h1);
        end
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        prev_rdata = 32'h0;

        // Randomised transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            rt.we    = 1'($urandom);
            rt.addr  = $urandom;
            rt.wdata = $urandom;
            rt.sel   = 4'($urandom);
            rt.sdata = $urandom;
            rt.delay = $urandom_range(1, 10);
            rt.ack   = ($urandom_range(0, 5) != 0);
            rt.err   = ($urandom_range(0, 4) == 0);
            rt.hold  = (i != 59) && 1'($urandom);
            rt = model(rt, prev_rdata);
            run_txn(rt);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
